multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Multicycle main control state machine: sequences each instruction through fetch, decode, execute, memory and write-back, and drives datapath enables and muxes. It sits directly upstream of the ALU control unit. Per state it emits the 2-bit `alu_op` and the datapath opcode/funct fields. The ALU control unit decodes those into the 6-bit ALU select.

## Interface
- Parameters: none. ALU op encodings are the `ALU_NOP`, `ALU_ADD`, `ALU_SUB` and `ALU` macros from the ALU function header. Opcode values are RISC-V RV32I.
- Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  7  IR[6:0]; valid from ID onward
- halt_req  in  1  from datapath: ECALL halt condition (x17 == 10)
- mem_ready  in  1  memory done; present only with `MEM_WAIT_EN`
- pc_write  out  1  unconditional PC write
- pc_write_cond  out  1  PC write if ALU branch result true
- pc_source  out  1  0 = ALU result, 1 = ALUOut
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read / mem_write  out  1 each  memory strobes
- ir_write  out  1  latch IR and old_pc
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
- reg_write  out  1  register file write
- alu_src_a  out  2  00 PC, 01 old_pc, 10 A
- alu_src_b  out  2  00 B, 01 constant 4, 10 immediate
- alu_op  out  2  to ALU control unit
- state  out  3  IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5
- is_halted  out  1  high in HALT
- retired_count  out  32  completed instruction count

## Operation
- Moore outputs: decoded from `state` plus `opcode`. Any output not listed for a state is 0. `alu_op` defaults to `ALU_NOP`.
- IF:
  - mem_read=1, i_or_d=0, ir_write=1, pc_write=1, pc_source=0
  - alu_src_a=00, alu_src_b=01, alu_op=ALU_ADD (PC+4)
  - Next state: ID.
- ID:
  - alu_src_a=01, alu_src_b=10, alu_op=ALU_ADD (target into ALUOut)
  - Next state: ECALL with halt_req → HALT; ECALL without halt_req → IF; JAL → WB; all other opcodes → EX.
- EX:
  - R-type: A,B, `ALU` → WB.
  - I-arith: A,imm, `ALU` → WB.
  - LOAD/STORE: A,imm, `ALU` → MEM.
  - JALR: A,imm, `ALU` → WB.
  - BRANCH: A,B, `ALU_SUB`, pc_write_cond=1, pc_source=1 → IF.
  - Unknown opcode: `ALU_NOP`, no writes → IF.
- MEM:
  - i_or_d=1.
  - LOAD: mem_read=1 → WB.
  - STORE: mem_write=1 → IF.
- WB:
  - LOAD: reg_write=1, mem_to_reg=01.
  - R/I: reg_write=1, mem_to_reg=00.
  - JAL: reg_write=1, mem_to_reg=10, pc_write=1, pc_source=1.
  - JALR: reg_write=1, mem_to_reg=10, pc_write=1, pc_source=0.
  - Next state: IF.
- HALT: sticky until reset. is_halted=1, all enables 0.
- retired_count: +1 on every transition into IF from a non-IF state, and on ID→HALT. Wraps 0xFFFFFFFF → 0.

## Timing
- Reset assertion:
  - Immediately: state=IF, retired_count=0, is_halted=0.
  - While reset is high: every enable is 0 and alu_op=ALU_NOP.
  - After release: first rising edge sees IF outputs.
- Reset mid-instruction: abandons it; no partial write after reset asserts.
- Cycles per instruction (no waits):
  - ECALL: 2
  - BRANCH, JAL: 3
  - R, I, JALR, STORE: 4
  - LOAD: 5
- `opcode` is sampled combinationally. It must be stable from the ID cycle until return to IF.

## Configuration
- `MEM_WAIT_EN` defined:
  - `mem_ready` port exists.
  - IF and MEM hold state while mem_ready=0, keeping mem_read, i_or_d and the ALU fields asserted.
  - ir_write, pc_write and mem_write assert only in the cycle mem_ready=1, and the transition happens that cycle.
  - reset still wins during a wait.
- `MEM_WAIT_EN` undefined: no `mem_ready` port; IF and MEM are always exactly one cycle.

## Test plan
- Reset pulse mid-EX → state=0, retired_count=0, all enables 0 during reset. After release, ir_write=1, alu_op=ALU_ADD.
- opcode=0110011 → states 0,1,2,4,0; EX alu_op=`ALU` with alu_src_a=10, alu_src_b=00; WB reg_write=1, mem_to_reg=00; retired_count 0→1.
- opcode=0000011 → 5 cycles; MEM mem_read=1, i_or_d=1; WB mem_to_reg=01. opcode=0100011 → MEM mem_write=1, then IF.
- opcode=1100011 → 3 cycles; EX alu_op=`ALU_SUB`, pc_write_cond=1, pc_source=1. opcode=1101111 → ID then WB with mem_to_reg=10, pc_write=1, pc_source=1.
- opcode=1110011 with halt_req=1 → HALT after ID; is_halted=1, enables 0 for 10+ cycles; retired_count incremented once.
- With `MEM_WAIT_EN`, mem_ready low for 3 cycles in IF → state stays 0 and ir_write=0. Cycle 4 (mem_ready=1) → ir_write=1, pc_write=1, next state ID.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle main control FSM: IF/ID/EX/MEM/WB sequencing and datapath controls.
// Optional memory handshake wait states are enabled by defining MEM_WAIT_EN.
`ifndef ALU_NOP
`define ALU_NOP 2'b00
`endif
`ifndef ALU_ADD
`define ALU_ADD 2'b01
`endif
`ifndef ALU_SUB
`define ALU_SUB 2'b10
`endif
`ifndef ALU
`define ALU 2'b11
`endif

module multicycle_control_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        halt_req,
`ifdef MEM_WAIT_EN
    input  logic        mem_ready,
`endif
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        pc_source,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic [1:0]  mem_to_reg,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [2:0]  state,
    output logic        is_halted,
    output logic [31:0] retired_count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t cur, nxt;
    logic   mem_rdy;
    logic   retire;

`ifdef MEM_WAIT_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur           <= S_IF;
            retired_count <= 32'd0;
        end else begin
            cur <= nxt;
            if (retire)
                retired_count <= retired_count + 32'd1;
        end
    end

    // An instruction completes when control leaves it for IF, or halts in ID.
    assign retire = ((nxt == S_IF) && (cur != S_IF)) ||
                    ((cur == S_ID) && (nxt == S_HALT));

    assign state     = cur;
    assign is_halted = (cur == S_HALT);

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 2'b00;
        reg_write     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = `ALU_NOP;
        nxt           = cur;

        // Outputs stay quiet while reset is held so nothing half-commits.
        if (!reset) begin
            unique case (cur)
                S_IF: begin
                    mem_read  = 1'b1;
                    ir_write  = mem_rdy;
                    pc_write  = mem_rdy;
                    alu_src_b = 2'b01;
                    alu_op    = `ALU_ADD;
                    if (mem_rdy)
                        nxt = S_ID;
                end
                S_ID: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    alu_op    = `ALU_ADD;
                    if (opcode == OP_SYSTEM)
                        nxt = halt_req ? S_HALT : S_IF;
                    else if (opcode == OP_JAL)
                        nxt = S_WB;
                    else
                        nxt = S_EX;
                end
                S_EX: begin
                    nxt = S_IF;
                    unique case (opcode)
                        OP_R: begin
                            alu_src_a = 2'b10;
                            alu_src_b = 2'b00;
                            alu_op    = `ALU;
                            nxt       = S_WB;
                        end
                        OP_I, OP_JALR: begin
                            alu_src_a = 2'b10;
                            alu_src_b = 2'b10;
                            alu_op    = `ALU;
                            nxt       = S_WB;
                        end
                        OP_LOAD, OP_STORE: begin
                            alu_src_a = 2'b10;
                            alu_src_b = 2'b10;
                            alu_op    = `ALU;
                            nxt       = S_MEM;
                        end
                        OP_BRANCH: begin
                            alu_src_a     = 2'b10;
                            alu_src_b     = 2'b00;
                            alu_op        = `ALU_SUB;
                            pc_write_cond = 1'b1;
                            pc_source     = 1'b1;
                        end
                        default: nxt = S_IF;
                    endcase
                end
                S_MEM: begin
                    i_or_d = 1'b1;
                    nxt    = S_IF;
                    if (opcode == OP_LOAD) begin
                        mem_read = 1'b1;
                        nxt      = mem_rdy ? S_WB : S_MEM;
                    end else if (opcode == OP_STORE) begin
                        mem_write = mem_rdy;
                        nxt       = mem_rdy ? S_IF : S_MEM;
                    end
                end
                S_WB: begin
                    nxt = S_IF;
                    unique case (opcode)
                        OP_LOAD: begin
                            reg_write  = 1'b1;
                            mem_to_reg = 2'b01;
                        end
                        OP_R, OP_I: begin
                            reg_write  = 1'b1;
                            mem_to_reg = 2'b00;
                        end
                        OP_JAL: begin
                            reg_write  = 1'b1;
                            mem_to_reg = 2'b10;
                            pc_write   = 1'b1;
                            pc_source  = 1'b1;
                        end
                        OP_JALR: begin
                            reg_write  = 1'b1;
                            mem_to_reg = 2'b10;
                            pc_write   = 1'b1;
                            pc_source  = 1'b0;
                        end
                        default: ;
                    endcase
                end
                S_HALT: nxt = S_HALT;
                default: nxt = S_IF;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: driver queues expectations,
// a negedge monitor pops and compares them.
module tb_multicycle_control_fsm;

    localparam logic [1:0] A_NOP = 2'b00;
    localparam logic [1:0] A_ADD = 2'b01;
    localparam logic [1:0] A_SUB = 2'b10;
    localparam logic [1:0] A_FN  = 2'b11;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JLR = 7'b1100111;
    localparam logic [6:0] OP_SYS = 7'b1110011;
    localparam logic [6:0] OP_UNK = 7'b0000000;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        halt_req;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, pc_source, i_or_d;
    logic        mem_read, mem_write, ir_write, reg_write, is_halted;
    logic [1:0]  mem_to_reg, alu_src_a, alu_src_b, alu_op;
    logic [2:0]  state;
    logic [31:0] retired_count;

    multicycle_control_fsm dut (
        .clk(clk),
        .reset(reset),
        .opcode(opcode),
        .halt_req(halt_req),
`ifdef MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .pc_write(pc_write),
        .pc_write_cond(pc_write_cond),
        .pc_source(pc_source),
        .i_or_d(i_or_d),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .ir_write(ir_write),
        .mem_to_reg(mem_to_reg),
        .reg_write(reg_write),
        .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b),
        .alu_op(alu_op),
        .state(state),
        .is_halted(is_halted),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] sig;
        logic [31:0] ret;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic [31:0] r = 32'd0;

    function automatic logic [19:0] mk(
        input logic pcw, input logic pcwc, input logic pcs,
        input logic iord, input logic mr, input logic mw,
        input logic irw, input logic [1:0] m2r, input logic rw,
        input logic [1:0] asa, input logic [1:0] asb,
        input logic [1:0] aop, input logic [2:0] st, input logic h);
        return {pcw, pcwc, pcs, iord, mr, mw, irw, m2r, rw,
                asa, asb, aop, st, h};
    endfunction

    logic [19:0] E_RST, E_IF, E_IFW, E_ID, E_EXR, E_EXI, E_EXB, E_EXU;
    logic [19:0] E_MLD, E_MST, E_WBA, E_WBL, E_WBJ, E_WBJR, E_HLT;

    always @(negedge clk) begin
        logic [19:0] act;
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            act = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read,
                   mem_write, ir_write, mem_to_reg, reg_write, alu_src_a,
                   alu_src_b, alu_op, state, is_halted};
            checks++;
            if (act !== e.sig) begin
                errors++;
                $display("FAIL %s ctrl: got %05h want %05h", e.nm, act, e.sig);
            end
            checks++;
            if (retired_count !== e.ret) begin
                errors++;
                $display("FAIL %s retired: got %0d want %0d",
                         e.nm, retired_count, e.ret);
            end
        end
    end

    task automatic cyc(input logic [6:0] op, input logic rs,
                       input logic hr, input logic mrdy,
                       input logic [19:0] s, input string nm);
        exp_t e;
        opcode    = op;
        reset     = rs;
        halt_req  = hr;
        mem_ready = mrdy;
        e.sig = s;
        e.ret = r;
        e.nm  = nm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [6:0] op, input logic [19:0] s,
                        input string nm);
        cyc(op, 1'b0, 1'b0, 1'b1, s, nm);
    endtask

    initial begin
        E_RST = mk(0,0,0,0,0,0,0,2'd0,0,2'd0,2'd0,A_NOP,3'd0,0);
        E_IF  = mk(1,0,0,0,1,0,1,2'd0,0,2'd0,2'd1,A_ADD,3'd0,0);
        E_IFW = mk(0,0,0,0,1,0,0,2'd0,0,2'd0,2'd1,A_ADD,3'd0,0);
        E_ID  = mk(0,0,0,0,0,0,0,2'd0,0,2'd1,2'd2,A_ADD,3'd1,0);
        E_EXR = mk(0,0,0,0,0,0,0,2'd0,0,2'd2,2'd0,A_FN ,3'd2,0);
        E_EXI = mk(0,0,0,0,0,0,0,2'd0,0,2'd2,2'd2,A_FN ,3'd2,0);
        E_EXB = mk(0,1,1,0,0,0,0,2'd0,0,2'd2,2'd0,A_SUB,3'd2,0);
        E_EXU = mk(0,0,0,0,0,0,0,2'd0,0,2'd0,2'd0,A_NOP,3'd2,0);
        E_MLD = mk(0,0,0,1,1,0,0,2'd0,0,2'd0,2'd0,A_NOP,3'd3,0);
        E_MST = mk(0,0,0,1,0,1,0,2'd0,0,2'd0,2'd0,A_NOP,3'd3,0);
        E_WBA = mk(0,0,0,0,0,0,0,2'd0,1,2'd0,2'd0,A_NOP,3'd4,0);
        E_WBL = mk(0,0,0,0,0,0,0,2'd1,1,2'd0,2'd0,A_NOP,3'd4,0);
        E_WBJ = mk(1,0,1,0,0,0,0,2'd2,1,2'd0,2'd0,A_NOP,3'd4,0);
        E_WBJR= mk(1,0,0,0,0,0,0,2'd2,1,2'd0,2'd0,A_NOP,3'd4,0);
        E_HLT = mk(0,0,0,0,0,0,0,2'd0,0,2'd0,2'd0,A_NOP,3'd5,1);

        reset = 1'b1; opcode = OP_UNK; halt_req = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        cyc(OP_R, 1'b1, 1'b0, 1'b1, E_RST, "por");

        step(OP_R, E_IF, "r_if");
        step(OP_R, E_ID, "r_id");
        step(OP_R, E_EXR, "r_ex");
        step(OP_R, E_WBA, "r_wb");
        r++;

        step(OP_LD, E_IF, "ld_if");
        step(OP_LD, E_ID, "ld_id");
        step(OP_LD, E_EXI, "ld_ex");
        step(OP_LD, E_MLD, "ld_mem");
        step(OP_LD, E_WBL, "ld_wb");
        r++;

        step(OP_ST, E_IF, "st_if");
        step(OP_ST, E_ID, "st_id");
        step(OP_ST, E_EXI, "st_ex");
        step(OP_ST, E_MST, "st_mem");
        r++;

        step(OP_BR, E_IF, "br_if");
        step(OP_BR, E_ID, "br_id");
        step(OP_BR, E_EXB, "br_ex");
        r++;

        step(OP_JAL, E_IF, "jal_if");
        step(OP_JAL, E_ID, "jal_id");
        step(OP_JAL, E_WBJ, "jal_wb");
        r++;

        step(OP_I, E_IF, "i_if");
        step(OP_I, E_ID, "i_id");
        step(OP_I, E_EXI, "i_ex");
        step(OP_I, E_WBA, "i_wb");
        r++;

        step(OP_JLR, E_IF, "jalr_if");
        step(OP_JLR, E_ID, "jalr_id");
        step(OP_JLR, E_EXI, "jalr_ex");
        step(OP_JLR, E_WBJR, "jalr_wb");
        r++;

        step(OP_SYS, E_IF, "ecall_if");
        step(OP_SYS, E_ID, "ecall_id");
        r++;

        step(OP_UNK, E_IF, "unk_if");
        step(OP_UNK, E_ID, "unk_id");
        step(OP_UNK, E_EXU, "unk_ex");
        r++;

        step(OP_R, E_IF, "rst_if");
        step(OP_R, E_ID, "rst_id");
        r = 32'd0;
        cyc(OP_R, 1'b1, 1'b0, 1'b1, E_RST, "rst_ex");
        cyc(OP_R, 1'b1, 1'b0, 1'b1, E_RST, "rst_hold");
        step(OP_R, E_IF, "rst_rel");

`ifdef MEM_WAIT_EN
        step(OP_R, E_ID, "w_r_id");
        step(OP_R, E_EXR, "w_r_ex");
        step(OP_R, E_WBA, "w_r_wb");
        r++;
        for (int i = 0; i < 3; i++)
            cyc(OP_R, 1'b0, 1'b0, 1'b0, E_IFW, "w_if_wait");
        cyc(OP_R, 1'b0, 1'b0, 1'b1, E_IF, "w_if_go");
        step(OP_R, E_ID, "w_id");
        step(OP_R, E_EXR, "w_ex");
        step(OP_R, E_WBA, "w_wb");
        r++;
        step(OP_SYS, E_IF, "h_if");
`endif
        cyc(OP_SYS, 1'b0, 1'b1, 1'b1, E_ID, "h_id");
        r++;
        for (int i = 0; i < 12; i++)
            cyc(OP_SYS, 1'b0, (i % 2 == 0), 1'b1, E_HLT, "halt");

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
